// File: rtl/ulaplus_palette_if.sv
// CPU bus bundle seen by the palette controller: I/O request strobes, address and write data.
interface cpu_bus;
   logic        ioreq;
   logic        rd;
   logic        wr;
   logic [15:0] a_reg;
   logic [7:0]  d_reg;

   modport slave  (input ioreq, rd, wr, a_reg, d_reg);
   modport master (output ioreq, rd, wr, a_reg, d_reg);
endinterface

// File: rtl/ulaplus_palette.sv
// ULAplus palette controller: CPU-accessible palette RAM shared with N time-multiplexed
// video lookup channels; a CPU access steals one lookup slot.
module ulaplus_palette #(
   parameter int          ADDR_W    = 6,
   parameter int          LOOKUPS   = 2,
   parameter logic [15:0] PORT_SEL  = 16'hbf3b,
   parameter logic [15:0] PORT_DATA = 16'hff3b
) (
   input  logic                        clk28,
   input  logic                        rst,
   input  logic                        en,
   cpu_bus.slave                       bus,
   output logic [7:0]                  d_out,
   output logic                        d_out_active,
   output logic                        active,
   output logic                        grayscale,
   input  logic [LOOKUPS*ADDR_W-1:0]   lookup_addr,
   output logic [LOOKUPS*8-1:0]        lookup_data
);

   localparam int SLOT_W = $clog2(LOOKUPS);
   localparam int DEPTH  = 2**ADDR_W;
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(LOOKUPS - 1);

   typedef enum logic [1:0] {
      GRP_PAL  = 2'b00,
      GRP_MODE = 2'b01,
      GRP_RSV2 = 2'b10,
      GRP_RSV3 = 2'b11
   } grp_t;

   logic              sel_cs, data_cs, cpu_wr, cpu_rd;
   logic              wr_q, rd_q, wr_rise, rd_rise;
   logic [7:0]        sel_reg;
   logic              wr_pend, rd_pend, rd_q_valid;
   logic [ADDR_W-1:0] wr_idx, rd_idx, ram_addr;
   logic [7:0]        wr_dat;
   grp_t              rd_grp;
   logic              port_wr, port_rd;
   logic [7:0]        ram_q, rd_byte;
   logic [7:0]        mem [DEPTH];
   logic [SLOT_W-1:0] s, tag;
   logic              tag_valid;

   always_comb begin
      sel_cs   = en & bus.ioreq & (bus.a_reg == PORT_SEL);
      data_cs  = en & bus.ioreq & (bus.a_reg == PORT_DATA);
      cpu_wr   = data_cs & bus.wr;
      cpu_rd   = data_cs & bus.rd;
      wr_rise  = cpu_wr & ~wr_q;
      rd_rise  = cpu_rd & ~rd_q;
      // A pending write always wins the port over a pending read.
      port_wr  = wr_pend & en;
      port_rd  = rd_pend & en & ~wr_pend;
      ram_addr = lookup_addr[s*ADDR_W +: ADDR_W];
      if (port_wr)
         ram_addr = wr_idx;
      else if (port_rd)
         ram_addr = rd_idx;
   end

   always_comb begin
      rd_byte = 8'h00;
      unique case (rd_grp)
         GRP_PAL:  rd_byte = ram_q;
         GRP_MODE: rd_byte = {6'b0, grayscale, active};
         default:  rd_byte = 8'h00;
      endcase
   end

   // NOTE: the palette RAM and its output register carry no reset so they map onto block RAM.
   always_ff @(posedge clk28) begin
      if (port_wr)
         mem[ram_addr] <= wr_dat;
      ram_q <= mem[ram_addr];
   end

   // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         wr_q         <= 1'b0;
         rd_q         <= 1'b0;
         sel_reg      <= 8'h00;
         wr_pend      <= 1'b0;
         wr_idx       <= '0;
         wr_dat       <= 8'h00;
         rd_pend      <= 1'b0;
         rd_idx       <= '0;
         rd_grp       <= GRP_PAL;
         rd_q_valid   <= 1'b0;
         active       <= 1'b0;
         grayscale    <= 1'b0;
         d_out        <= 8'h00;
         d_out_active <= 1'b0;
         s            <= '0;
         tag          <= '0;
         tag_valid    <= 1'b0;
         lookup_data  <= '0;
      end else begin
         wr_q <= cpu_wr;
         rd_q <= cpu_rd;
         if (sel_cs && bus.wr)
            sel_reg <= bus.d_reg;

         if (port_wr)
            wr_pend <= 1'b0;
         if (port_rd)
            rd_pend <= 1'b0;
         rd_q_valid <= port_rd;

         if (wr_rise && grp_t'(sel_reg[7:6]) == GRP_PAL) begin
            wr_pend <= 1'b1;
            wr_idx  <= sel_reg[ADDR_W-1:0];
            wr_dat  <= bus.d_reg;
         end
         if (wr_rise && sel_reg == 8'h40) begin
            active    <= bus.d_reg[0];
            grayscale <= bus.d_reg[1];
         end
         if (rd_rise) begin
            rd_pend <= 1'b1;
            rd_idx  <= sel_reg[ADDR_W-1:0];
            rd_grp  <= grp_t'(sel_reg[7:6]);
         end

         if (!en) begin
            active     <= 1'b0;
            grayscale  <= 1'b0;
            wr_pend    <= 1'b0;
            rd_pend    <= 1'b0;
            rd_q_valid <= 1'b0;
         end

         // Readback only lands if the CPU is still holding the read.
         if (rd_q_valid && cpu_rd)
            d_out <= rd_byte;
         d_out_active <= cpu_rd & (d_out_active | rd_q_valid);

         s         <= (s == SLOT_LAST) ? '0 : s + 1'b1;
         tag       <= s;
         tag_valid <= ~(port_wr | port_rd);
         if (tag_valid)
            lookup_data[tag*8 +: 8] <= ram_q;
      end
   end

endmodule
